addsub_arbiter: RTL and testbench

ADDSUB_ARBITER -- requirements
Module: addsub_arbiter

---
 rtl/addsub_arbiter_if.sv | 37 +++
 rtl/addsub_arbiter.sv | 125 ++++++++++++
 tb/tb_addsub_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/addsub_arbiter_if.sv
// Bundle of the two requester ports and the result port of addsub_arbiter.
// A transfer happens on any rising edge where valid and ready are both high; once
// valid is raised the source keeps it and its payload stable until that transfer.
interface addsub_arbiter_if #(parameter int WIDTH = 4);
  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic             req0_op;
  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic             req1_op;
  logic             res_valid;
  logic             res_ready;
  logic             res_id;
  logic [WIDTH-1:0] res_sum;
  logic             res_cout;
  logic             res_ovf;

  modport master (
    output req0_valid, req0_a, req0_b, req0_op,
    output req1_valid, req1_a, req1_b, req1_op,
    output res_ready,
    input  req0_ready, req1_ready,
    input  res_valid, res_id, res_sum, res_cout, res_ovf
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op,
    input  req1_valid, req1_a, req1_b, req1_op,
    input  res_ready,
    output req0_ready, req1_ready,
    output res_valid, res_id, res_sum, res_cout, res_ovf
  );
endinterface

// File: rtl/addsub_arbiter.sv
// Two-requester round-robin front end sharing one add/subtract datapath.
// Fixed latency: operands captured on accept, result published two edges later.
module addsub_arbiter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  addsub_arbiter_if.slave  bus,
  output logic             busy,
  output logic [7:0]       ops_done,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state;
  logic             last_id;
  logic             exec_ph;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             op_q;
  logic             id_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;

  logic             grant0;
  logic             grant1;
  logic [WIDTH-1:0] b_x;
  logic [WIDTH:0]   full;
  logic             carry_msb;

  // On a tie the requester that was not served last wins.
  assign grant0 = bus.req0_valid & (~bus.req1_valid | last_id);
  assign grant1 = bus.req1_valid & (~bus.req0_valid | ~last_id);

  assign bus.req0_ready = (state == IDLE) & grant0;
  assign bus.req1_ready = (state == IDLE) & grant1;

  assign b_x       = b_q ^ {WIDTH{op_q}};
  assign full      = {1'b0, a_q} + {1'b0, b_x} + {{WIDTH{1'b0}}, op_q};
  assign carry_msb = full[WIDTH-1] ^ a_q[WIDTH-1] ^ b_x[WIDTH-1];

  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      last_id      <= 1'b1;
      exec_ph      <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= 1'b0;
      id_q         <= 1'b0;
      sum_q        <= '0;
      cout_q       <= 1'b0;
      ovf_q        <= 1'b0;
      bus.res_valid <= 1'b0;
      bus.res_id    <= 1'b0;
      bus.res_sum   <= '0;
      bus.res_cout  <= 1'b0;
      bus.res_ovf   <= 1'b0;
      busy         <= 1'b0;
      ops_done     <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req0_ready) begin
            a_q     <= bus.req0_a;
            b_q     <= bus.req0_b;
            op_q    <= bus.req0_op;
            id_q    <= 1'b0;
            last_id <= 1'b0;
            exec_ph <= 1'b0;
            busy    <= 1'b1;
            state   <= EXEC;
          end else if (bus.req1_ready) begin
            a_q     <= bus.req1_a;
            b_q     <= bus.req1_b;
            op_q    <= bus.req1_op;
            id_q    <= 1'b1;
            last_id <= 1'b1;
            exec_ph <= 1'b0;
            busy    <= 1'b1;
            state   <= EXEC;
          end
        end
        EXEC: begin
          // First edge registers the datapath, second publishes it to the consumer.
          if (!exec_ph) begin
            sum_q   <= full[WIDTH-1:0];
            cout_q  <= full[WIDTH];
            ovf_q   <= carry_msb ^ full[WIDTH];
            exec_ph <= 1'b1;
          end else begin
            bus.res_valid <= 1'b1;
            bus.res_id    <= id_q;
            bus.res_sum   <= sum_q;
            bus.res_cout  <= cout_q;
            bus.res_ovf   <= ovf_q;
            exec_ph       <= 1'b0;
            state         <= RESP;
          end
        end
        RESP: begin
          if (bus.res_ready) begin
            bus.res_valid <= 1'b0;
            busy          <= 1'b0;
            ops_done      <= ops_done + 8'd1;
            state         <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_addsub_arbiter.sv
// Bench for addsub_arbiter: directed scenarios plus randomized traffic, all checked
// against an arithmetic reference model with a queue of expected results.
module tb_addsub_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       busy;
  logic [7:0] ops_done;
  logic [1:0] dbg_state;

  addsub_arbiter_if #(.WIDTH(4)) bus ();

  addsub_arbiter #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .busy      (busy),
    .ops_done  (ops_done),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state: arbiter free, cycles until result, result pending.
  bit         m_free;
  int         m_cnt;
  bit         m_resp;
  bit         m_last;
  logic [7:0] m_ops;
  int         hs_total;
  logic [6:0] exp_q[$];
  int         grant_log[$];
  bit         acc0, acc1;

  logic       obs_id;
  logic [3:0] obs_sum;
  logic       obs_cout, obs_ovf;

  bit         pv[2];
  int         pa[2], pb[2];
  bit         po[2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // {sum, cout, ovf} from plain integer arithmetic.
  function automatic logic [5:0] ref_calc(input int a, input int b, input bit op);
    int r, sa, sb, sr;
    logic [3:0] s;
    logic c, v;
    r  = op ? a - b : a + b;
    s  = r[3:0];
    c  = op ? (a >= b) : (a + b > 15);
    sa = (a > 7) ? a - 16 : a;
    sb = (b > 7) ? b - 16 : b;
    sr = op ? sa - sb : sa + sb;
    v  = (sr > 7) || (sr < -8);
    return {s, c, v};
  endfunction

  task automatic model_reset();
    m_free   = 1'b1;
    m_cnt    = 0;
    m_resp   = 1'b0;
    m_last   = 1'b1;
    m_ops    = 8'd0;
    hs_total = 0;
    exp_q.delete();
    grant_log.delete();
    pv[0] = 1'b0;
    pv[1] = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_res_valid"}, bus.res_valid, 0);
    check({tag, "_res_id"},    bus.res_id, 0);
    check({tag, "_res_sum"},   bus.res_sum, 0);
    check({tag, "_res_cout"},  bus.res_cout, 0);
    check({tag, "_res_ovf"},   bus.res_ovf, 0);
    check({tag, "_busy"},      busy, 0);
    check({tag, "_ops_done"},  ops_done, 0);
    check({tag, "_state"},     dbg_state, 0);
  endtask

  task automatic do_reset(input string tag);
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    bus.res_ready  = 1'b0;
    rst_n = 1'b0;
    #1;
    check_reset_outputs(tag);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One clock cycle: drive at negedge, compare shortly after, advance the model
  // to what the coming rising edge must do.
  task automatic step(input bit v0, input int a0, input int b0, input bit o0,
                      input bit v1, input int a1, input int b1, input bit o1,
                      input bit rr);
    bit e0, e1;
    logic [6:0] e;
    @(negedge clk);
    bus.req0_valid = v0;
    bus.req0_a     = 4'(a0);
    bus.req0_b     = 4'(b0);
    bus.req0_op    = o0;
    bus.req1_valid = v1;
    bus.req1_a     = 4'(a1);
    bus.req1_b     = 4'(b1);
    bus.req1_op    = o1;
    bus.res_ready  = rr;
    #1;
    e0 = m_free && v0 && (!v1 || m_last);
    e1 = m_free && v1 && (!v0 || !m_last);
    check("req0_ready", bus.req0_ready, e0);
    check("req1_ready", bus.req1_ready, e1);
    check("ready_excl", bus.req0_ready & bus.req1_ready, 0);
    check("res_valid", bus.res_valid, m_resp);
    check("busy", busy, !m_free);
    check("ops_done", ops_done, m_ops);
    if (m_resp && exp_q.size() > 0) begin
      e = exp_q[0];
      check("res_id", bus.res_id, e[6]);
      check("res_sum", bus.res_sum, e[5:2]);
      check("res_cout", bus.res_cout, e[1]);
      check("res_ovf", bus.res_ovf, e[0]);
    end
    if (bus.res_valid) begin
      obs_id   = bus.res_id;
      obs_sum  = bus.res_sum;
      obs_cout = bus.res_cout;
      obs_ovf  = bus.res_ovf;
    end
    if (bus.req0_ready) grant_log.push_back(0);
    if (bus.req1_ready) grant_log.push_back(1);
    acc0 = e0;
    acc1 = e1;
    if (m_resp && rr) begin
      m_resp = 1'b0;
      m_free = 1'b1;
      m_ops  = m_ops + 8'd1;
      hs_total++;
      void'(exp_q.pop_front());
    end else if (m_cnt > 0) begin
      m_cnt--;
      if (m_cnt == 0) m_resp = 1'b1;
    end
    if (e0) exp_q.push_back({1'b0, ref_calc(a0, b0, o0)});
    if (e1) exp_q.push_back({1'b1, ref_calc(a1, b1, o1)});
    if (e0 || e1) begin
      m_last = e1;
      m_free = 1'b0;
      m_cnt  = 2;
    end
  endtask

  task automatic run_op(input bit id, input int a, input int b, input bit op);
    bit done = 1'b0;
    for (int k = 0; k < 20 && !done; k++) begin
      if (id) step(0, 0, 0, 0, 1, a, b, op, 1);
      else    step(1, a, b, op, 0, 0, 0, 0, 1);
      done = id ? acc1 : acc0;
    end
    check("tmo_accept", done, 1);
  endtask

  task automatic wait_free();
    for (int k = 0; k < 20 && !m_free; k++) step(0, 0, 0, 0, 0, 0, 0, 0, 1);
    check("tmo_free", m_free, 1);
  endtask

  // Requesters raise valid with probability prob and hold it until accepted;
  // operand lines carry junk while valid is low.
  task automatic rand_cycle(input int prob, input int rr_prob);
    int da[2], db[2];
    bit dop[2];
    for (int i = 0; i < 2; i++) begin
      if (!pv[i] && $urandom_range(0, 99) < prob) begin
        pv[i] = 1'b1;
        pa[i] = $urandom_range(0, 15);
        pb[i] = $urandom_range(0, 15);
        po[i] = $urandom_range(0, 1);
      end
      da[i]  = pv[i] ? pa[i] : $urandom_range(0, 15);
      db[i]  = pv[i] ? pb[i] : $urandom_range(0, 15);
      dop[i] = pv[i] ? po[i] : 1'($urandom_range(0, 1));
    end
    step(pv[0], da[0], db[0], dop[0], pv[1], da[1], db[1], dop[1],
         $urandom_range(0, 99) < rr_prob);
    if (acc0) pv[0] = 1'b0;
    if (acc1) pv[1] = 1'b0;
  endtask

  initial begin
    int ops_before;
    bus.req0_valid = 1'b0;
    bus.req0_a     = '0;
    bus.req0_b     = '0;
    bus.req0_op    = 1'b0;
    bus.req1_valid = 1'b0;
    bus.req1_a     = '0;
    bus.req1_b     = '0;
    bus.req1_op    = 1'b0;
    bus.res_ready  = 1'b0;
    rst_n = 1'b0;
    model_reset();
    #12;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // 5 + 3
    run_op(0, 5, 3, 0);
    wait_free();
    check("add53_sum", obs_sum, 8);
    check("add53_cout", obs_cout, 0);
    check("add53_ovf", obs_ovf, 1);
    check("add53_id", obs_id, 0);

    // 7 - 2 and 2 - 7 on requester 1
    run_op(1, 7, 2, 1);
    wait_free();
    check("sub72_sum", obs_sum, 5);
    check("sub72_cout", obs_cout, 1);
    check("sub72_ovf", obs_ovf, 0);
    check("sub72_id", obs_id, 1);
    run_op(1, 2, 7, 1);
    wait_free();
    check("sub27_sum", obs_sum, 11);
    check("sub27_cout", obs_cout, 0);
    check("sub27_ovf", obs_ovf, 0);

    // Consumer stalls five cycles while the other requester waits.
    run_op(0, 9, 4, 0);
    ops_before = m_ops;
    for (int k = 0; k < 7; k++) step(0, 0, 0, 0, 1, 12, 3, 1, 0);
    check("stall_busy", busy, 1);
    check("stall_valid", bus.res_valid, 1);
    check("stall_sum", bus.res_sum, 13);
    wait_free();
    @(posedge clk);
    #1;
    check("stall_ops", ops_done, 8'(ops_before + 1));

    // Reset while the operation is still executing.
    run_op(0, 3, 3, 1);
    @(posedge clk);
    #2;
    check("exec_state", dbg_state, 1);
    do_reset("exec_rst");
    for (int k = 0; k < 4; k++) step(0, 0, 0, 0, 0, 0, 0, 0, 1);
    run_op(1, 6, 9, 0);
    wait_free();
    check("post_rst_sum", obs_sum, 15);
    check("post_rst_cout", obs_cout, 0);
    check("post_rst_ovf", obs_ovf, 0);

    // Both requesters valid from reset: grants must alternate starting at 0.
    do_reset("rr_rst");
    for (int k = 0; k < 40 && hs_total < 4; k++) rand_cycle(100, 100);
    check("tmo_rr", hs_total >= 4, 1);
    @(posedge clk);
    #1;
    check("rr_ops", ops_done, 4);
    check("rr_log_len", grant_log.size() >= 4, 1);
    if (grant_log.size() >= 4) begin
      check("rr_grant0", grant_log[0], 0);
      check("rr_grant1", grant_log[1], 1);
      check("rr_grant2", grant_log[2], 0);
      check("rr_grant3", grant_log[3], 1);
    end

    // 256 back-to-back results wrap the counter.
    do_reset("wrap_rst");
    for (int k = 0; k < 1200 && hs_total < 256; k++) rand_cycle(100, 100);
    check("tmo_wrap", hs_total >= 256, 1);
    @(posedge clk);
    #1;
    check("wrap_ops", ops_done, 0);

    // Random traffic with random consumer back-pressure.
    for (int k = 0; k < 500; k++) rand_cycle(50, 60);
    for (int k = 0; k < 4; k++) begin
      pv[0] = 1'b0;
      pv[1] = 1'b0;
      rand_cycle(0, 100);
    end
    wait_free();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
